// File: rtl/lattice_bank_scheduler.sv
// -----------------------------------------------------------------------------
// lattice_bank_scheduler
//
// Shares the 9-bank D2Q9 lattice BRAM array between the compute-engine
// write-back port and a frame readout that streams all DEPTH cells over
// AXI-Stream. Owns the (registered) bank address, write enable and write data.
// A 2-entry output buffer absorbs the 1-cycle BRAM read latency so the stream
// sustains one beat per cycle and never drops data under backpressure.
//
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   frame_ready                      : single-cycle request to stream a frame
//   wr_valid / wr_ready              : write-back handshake (ready only in IDLE)
//   wr_addr / wr_data                : write cell index and 9-lane data
//   bram_addr / bram_we / bram_wdata : registered shared bank controls
//   bram_rdata                       : bank read data, valid the cycle after issue
//   m00_axis_t*                      : AXI-Stream master (tstrb all ones)
//   busy                             : readout in progress
//   frame_done                       : one-cycle pulse after the last beat
//
// Build option: define LBS_FRAME_QUEUE_EN to remember one frame request that
// arrives during a readout and start it immediately after the current frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lattice_bank_scheduler #(
    parameter int DATA_WIDTH    = 16,
    parameter int LANES         = 9,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                            m00_axis_aclk,
    input  logic                            m00_axis_aresetn,
    input  logic                            frame_ready,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDRESS_WIDTH-1:0]        wr_addr,
    input  logic [LANES*DATA_WIDTH-1:0]     wr_data,
    output logic [ADDRESS_WIDTH-1:0]        bram_addr,
    output logic                            bram_we,
    output logic [LANES*DATA_WIDTH-1:0]     bram_wdata,
    input  logic [LANES*DATA_WIDTH-1:0]     bram_rdata,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    output logic [LANES*DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [LANES*DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                            m00_axis_tlast,
    output logic                            busy,
    output logic                            frame_done
);
    localparam int W = LANES * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic [ADDRESS_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic                     bram_we_q, bram_we_d;
    logic [W-1:0]             bram_wdata_q, bram_wdata_d;
    logic                     busy_q, busy_d;
    logic                     frame_done_q, frame_done_d;
`ifdef LBS_FRAME_QUEUE_EN
    logic                     pending_q, pending_d;
`endif

    // Output buffer: two slots, pointer pair plus occupancy count.
    logic [W-1:0]             buf_data_q [2];
    logic                     buf_last_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               count_q;

    logic                     push_s, pop_s, issue_ok_s, wr_ready_s;
    logic [2:0]               occ_s;

    // Data returning from the bank always lands in the buffer; room is
    // reserved at issue time so a push can never find the buffer full.
    assign push_s     = inflight_q;
    assign pop_s      = (count_q != 2'd0) && m00_axis_tready;
    assign occ_s      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign issue_ok_s = (occ_s < 3'd2);

    // Next-state, bank control and readout sequencing.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        bram_addr_d     = bram_addr_q;
        bram_we_d       = 1'b0;
        bram_wdata_d    = bram_wdata_q;
        busy_d          = busy_q;
        frame_done_d    = 1'b0;
        wr_ready_s      = 1'b0;
`ifdef LBS_FRAME_QUEUE_EN
        pending_d       = pending_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A frame request takes priority; the write stalls that cycle.
                wr_ready_s = !frame_ready;
                if (frame_ready) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (wr_valid) begin
                    bram_we_d    = 1'b1;
                    bram_addr_d  = wr_addr;
                    bram_wdata_d = wr_data;
                end else begin
                    bram_we_d = 1'b0;
                end
            end
            ST_READ: begin
`ifdef LBS_FRAME_QUEUE_EN
                if (frame_ready) pending_d = 1'b1;
                else             pending_d = pending_q;
`endif
                if (issue_ok_s) begin
                    bram_addr_d     = cnt_q;
                    cnt_d           = cnt_q + ADDRESS_WIDTH'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (cnt_q == LAST_ADDR);
                    if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
                    else                    state_d = ST_READ;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && buf_last_q[rd_ptr_q]) begin
                    frame_done_d = 1'b1;
`ifdef LBS_FRAME_QUEUE_EN
                    if (pending_q || frame_ready) begin
                        state_d   = ST_READ;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
`endif
                end else begin
`ifdef LBS_FRAME_QUEUE_EN
                    if (frame_ready) pending_d = 1'b1;
                    else             pending_d = pending_q;
`endif
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            bram_addr_q     <= '0;
            bram_we_q       <= 1'b0;
            bram_wdata_q    <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
`ifdef LBS_FRAME_QUEUE_EN
            pending_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            bram_addr_q     <= bram_addr_d;
            bram_we_q       <= bram_we_d;
            bram_wdata_q    <= bram_wdata_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
`ifdef LBS_FRAME_QUEUE_EN
            pending_q       <= pending_d;
`endif
        end
    end

    // Output buffer storage and pointers.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                buf_data_q[wr_ptr_q] <= bram_rdata;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign wr_ready        = wr_ready_s;
    assign bram_addr       = bram_addr_q;
    assign bram_we         = bram_we_q;
    assign bram_wdata      = bram_wdata_q;
    assign m00_axis_tvalid = (count_q != 2'd0);
    assign m00_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m00_axis_tlast  = (count_q != 2'd0) && buf_last_q[rd_ptr_q];
    assign m00_axis_tstrb  = {(W/8){1'b1}};
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;

    lattice_bank_scheduler_chk u_chk (
        .clk_i    (m00_axis_aclk),
        .rst_ni   (m00_axis_aresetn),
        .count_i  (count_q),
        .push_i   (push_s),
        .pop_i    (pop_s)
    );
endmodule

// Buffer safety properties kept apart from the datapath.
module lattice_bank_scheduler_chk (
    input logic       clk_i,
    input logic       rst_ni,
    input logic [1:0] count_i,
    input logic       push_i,
    input logic       pop_i
);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(count_i == 2'd2 && push_i && !pop_i));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_i != 2'd3);
endmodule

// File: tb/tb_lattice_bank_scheduler.sv
`timescale 1ns/1ps
module tb_lattice_bank_scheduler;
    localparam int DW = 16;
    localparam int LN = 9;
    localparam int DEPTH = 2500;
    localparam int AW = 12;
    localparam int W = LN * DW;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_ready, wr_valid, wr_ready;
    logic [AW-1:0] wr_addr, bram_addr;
    logic [W-1:0]  wr_data, bram_wdata, bram_rdata, tdata;
    logic          bram_we, tvalid, tlast, busy, frame_done;
    logic          tready = 1'b1;
    logic [W/8-1:0] tstrb;
    logic          bp_en;

    logic [W-1:0]  bram_mem [4096];
    logic [W-1:0]  exp_mem  [DEPTH];
    beat_t         exp_q [$];

    int total = 0;
    int bad = 0;
    int beats_seen = 0;
    logic pend_done = 1'b0;
    logic stall_prev = 1'b0;
    logic [W-1:0] prev_d;
    logic prev_l;

    always #5 clk = ~clk;

    lattice_bank_scheduler #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
        .frame_ready(frame_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .m00_axis_tvalid(tvalid), .m00_axis_tready(tready), .m00_axis_tdata(tdata),
        .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast),
        .busy(busy), .frame_done(frame_done)
    );

    // Bank model: asynchronous read of the registered address, write on the edge.
    assign bram_rdata = bram_mem[bram_addr];
    always @(posedge clk) begin
        if (bram_we) bram_mem[bram_addr] = bram_wdata;
    end

    // Random backpressure when enabled, otherwise always ready.
    always @(posedge clk) begin
        #1;
        if (bp_en) tready = 1'($urandom_range(0, 1));
        else       tready = 1'b1;
    end

    function automatic logic [W-1:0] pat(input int i);
        logic [W-1:0] p;
        for (int k = 0; k < LN; k++) p[DW*k +: DW] = 16'(i * 16 + k);
        return p;
    endfunction

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected beat per handshake.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            pend_done  = 1'b0;
        end else begin
            if (frame_done || pend_done) begin
                total++;
                if (frame_done !== pend_done) begin
                    bad++;
                    $display("FAIL frame_done: got %0b expected %0b", frame_done, pend_done);
                end
            end
            pend_done = 1'b0;
            if (stall_prev) begin
                total++;
                if (!tvalid || tdata !== prev_d || tlast !== prev_l) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                             tvalid, tdata, tlast, prev_d, prev_l);
                end
            end
            if (tvalid && tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: got beat %h expected none", tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e.d || tlast !== e.l) begin
                        bad++;
                        $display("FAIL beat%0d: got d=%h l=%0b expected d=%h l=%0b",
                                 beats_seen, tdata, tlast, e.d, e.l);
                    end
                    if (e.l) pend_done = 1'b1;
                end
                beats_seen++;
            end
            stall_prev = tvalid && !tready;
            prev_d = tdata;
            prev_l = tlast;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({exp_mem[i], (i == DEPTH - 1)});
    endtask

    task automatic pulse_frame();
        step();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output int we_cnt);
        n = -1;
        we_cnt = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bram_we) we_cnt++;
            if (frame_done) begin
                n = k;
                break;
            end
        end
        if (n < 0) chk_int("done_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int target);
        int k;
        for (k = 0; k < 6000 && beats_seen < target; k++) @(negedge clk);
        if (beats_seen < target) chk_int("beats_timeout", beats_seen, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wec, tv;
        logic [W-1:0] d5, d7;
        rst_n = 1'b0; frame_ready = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; bp_en = 1'b0;
        for (int i = 0; i < 4096; i++) bram_mem[i] = pat(i);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
        for (int k = 0; k < LN; k++) d5[DW*k +: DW] = 16'(k + 1);
        for (int k = 0; k < LN; k++) d7[DW*k +: DW] = 16'(16'hA000 + k);

        // Reset state
        #2;
        chk_int("rst_tvalid", int'(tvalid), 0);
        chk_int("rst_tlast", int'(tlast), 0);
        chk_w("rst_tdata", tdata, '0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_done", int'(frame_done), 0);
        chk_int("rst_we", int'(bram_we), 0);
        chk_int("rst_addr", int'(bram_addr), 0);
        chk_w("rst_wdata", bram_wdata, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_int("idle_wr_ready", int'(wr_ready), 1);
        chk_int("tstrb", int'(tstrb), 32'h3FFFF);

        // Write cell 5 in IDLE
        step();
        wr_valid = 1'b1; wr_addr = 12'd5; wr_data = d5;
        @(negedge clk);
        chk_int("wr5_ready", int'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk_int("wr5_we", int'(bram_we), 1);
        chk_int("wr5_addr", int'(bram_addr), 5);
        chk_w("wr5_wdata", bram_wdata, d5);
        exp_mem[5] = d5;
        @(negedge clk);
        chk_int("wr5_we_off", int'(bram_we), 0);

        // Full frame with tready held high: latency and throughput
        beats_seen = 0;
        push_frame();
        pulse_frame();
        @(negedge clk);
        chk_int("f1_busy", int'(busy), 1);
        chk_int("f1_tvalid_c1", int'(tvalid), 0);
        chk_int("f1_wr_ready", int'(wr_ready), 0);
        @(negedge clk);
        chk_int("f1_tvalid_c2", int'(tvalid), 0);
        @(negedge clk);
        chk_int("f1_tvalid_c3", int'(tvalid), 1);
        wait_done(3000, n, wec);
        chk_int("f1_cycles", n, 2500);
        chk_int("f1_beats", beats_seen, DEPTH);
        chk_int("f1_busy_end", int'(busy), 0);

        // Collision: frame and write in the same cycle
        step();
        frame_ready = 1'b1; wr_valid = 1'b1; wr_addr = 12'd7; wr_data = d7;
        push_frame();
        @(negedge clk);
        chk_int("col_wr_ready", int'(wr_ready), 0);
        step();
        frame_ready = 1'b0;
        @(negedge clk);
        chk_int("col_we", int'(bram_we), 0);
        chk_int("col_busy", int'(busy), 1);
        wait_done(3000, n, wec);
        chk_int("col_we_cnt", wec, 0);
        chk_int("col_ready_after", int'(wr_ready), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        chk_int("col_we_late", int'(bram_we), 1);
        chk_int("col_addr_late", int'(bram_addr), 7);
        chk_w("col_wdata_late", bram_wdata, d7);
        exp_mem[7] = d7;

        // Random backpressure frame
        beats_seen = 0;
        push_frame();
        bp_en = 1'b1;
        pulse_frame();
        wait_done(20000, n, wec);
        bp_en = 1'b0;
        chk_int("bp_beats", beats_seen, DEPTH);

        // Reset mid-frame
        beats_seen = 0;
        push_frame();
        pulse_frame();
        wait_beats(1000);
        #2 rst_n = 1'b0;
        #1;
        chk_int("mid_rst_tvalid", int'(tvalid), 0);
        chk_int("mid_rst_tlast", int'(tlast), 0);
        chk_int("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        beats_seen = 0;
        push_frame();
        pulse_frame();
        wait_done(3000, n, wec);
        chk_int("restart_cycles", n, 2503);
        chk_int("restart_beats", beats_seen, DEPTH);

        // Second request during READ
        beats_seen = 0;
        push_frame();
        pulse_frame();
        wait_beats(300);
        step();
        frame_ready = 1'b1;
`ifdef LBS_FRAME_QUEUE_EN
        push_frame();
`endif
        step();
        frame_ready = 1'b0;
        wait_done(3000, n, wec);
`ifdef LBS_FRAME_QUEUE_EN
        chk_int("q_busy_kept", int'(busy), 1);
        chk_int("q_no_window", int'(wr_ready), 0);
        wait_done(3000, n, wec);
        chk_int("q_second_cycles", n, 2502);
        chk_int("q_beats", beats_seen, 2 * DEPTH);
`else
        chk_int("nq_busy", int'(busy), 0);
        chk_int("nq_wr_ready", int'(wr_ready), 1);
        tv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tvalid) tv++;
        end
        chk_int("nq_no_second", tv, 0);
        chk_int("nq_beats", beats_seen, DEPTH);
`endif
        chk_int("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
